sreg_rnd: RTL and testbench
===========================

// Module: sreg_rnd
// PURPOSE
//  Parametrised cipher state register with an integrated round sequencer.
//  - Loads an initial state, applies ROUNDS next-state updates from the round function, then flags completion.
//  - Supports stall and restart.
//  - Sits between the round-function datapath (drives nxt) and the cipher top.
//  - The cipher top consumes rnd for key-schedule/constant indexing and don for output capture.
// PARAMETERS
//  W       64   state width in bits (bit 0 = MSB, ports declared [0:W-1])
//  ROUNDS  31   number of nxt updates per operation; legal range >= 1
//  RW      5    round counter width; must satisfy 2**RW > ROUNDS
// PORTS
//  ck   in   1    rising-edge clock
//  rn   in   1    reset, asynchronous, active low
//  sta  in   1    start: load inp, begin operation (level sampled each cycle)
//  stl  in   1    stall: freeze state and counter during RUN
//  inp  in   W    initial state data
//  nxt  in   W    next state from round function (combinational from out, rnd)
//  out  out  W    registered state
//  rnd  out  RW   registered round index of the state currently on out
//  bsy  out  1    registered: high while in RUN
//  don  out  1    registered: one-cycle completion pulse; out holds final state
// BEHAVIOUR
//  Reset (rn low, async): out=0, rnd=0, bsy=0, don=0, FSM=IDLE; aborts any operation immediately.
//  FSM states: IDLE, RUN, DONE. Outputs are registered; bsy=(FSM==RUN), don=(FSM==DONE).
//  Priority each edge: sta > stl > update.
//  IDLE:
//   - sta=1 -> out<=inp, rnd<=0, ->RUN.
//   - else hold.
//  RUN:
//   - sta=1 -> restart: out<=inp, rnd<=0, stay RUN.
//   - else stl=1 -> hold out and rnd.
//   - else out<=nxt, rnd<=rnd+1; if rnd==ROUNDS-1 before the edge, ->DONE.
//  DONE (exactly one cycle):
//   - sta=1 -> out<=inp, rnd<=0, ->RUN; don drops on that edge.
//   - else ->IDLE; out and rnd hold (see CONFIGURATION).
//   - stl is ignored in DONE.
//  Latency:
//   - sta sampled at edge E0 -> out=inp after E0.
//   - With no stalls, don=1 in the cycle after edge E0+ROUNDS; rnd=ROUNDS, out=final state.
//   - Each stalled RUN cycle adds exactly one cycle.
//  rnd never exceeds ROUNDS and never wraps; the arithmetic is RW-bit unsigned.
//  nxt is only sampled in RUN with sta=0, stl=0; it is don't-care otherwise.
//  sta held high continuously keeps reloading: rnd stays 0, don never asserts.
//  ROUNDS=1: one update then DONE, i.e. don one cycle after the first RUN cycle.
//  Elaboration check: $error if ROUNDS<1 or 2**RW<=ROUNDS.
// CONFIGURATION
//  SREG_ZEROIZE_EN defined:
//   - On DONE->IDLE (DONE with sta=0): out<=0, rnd<=0.
//   - The final state is visible only during the don cycle.
//  SREG_ZEROIZE_EN undefined:
//   - On DONE->IDLE, out and rnd hold their final values until the next sta or reset.
//  All other behaviour is identical in both builds.
// TESTING  (W=64, ROUNDS=31, RW=5, bench drives nxt=out+1 unless stated)
//  1 Reset:
//    - rn low mid-RUN at rnd=10 -> out=0, rnd=0, bsy=0, don=0 without waiting for a ck edge.
//    - After rn rises, the block idles until sta.
//  2 Basic run:
//    - sta one cycle with inp=64'h0123456789ABCDEF.
//    - -> bsy=1 for 31 cycles; then don=1 one cycle with out=64'h0123456789ABCE0E and rnd=31.
//  3 Stall:
//    - As test 2, with stl high for 5 cycles at rnd=7 -> out/rnd frozen during the stall.
//    - don arrives 5 cycles later than in test 2 with the same final out.
//  4 Restart/priority:
//    - sta and stl both high at rnd=20 with inp=0 -> out=0, rnd=0.
//    - Then 31 updates; don with out=64'h1F.
//  5 Back-to-back:
//    - sta in the DONE cycle -> next cycle bsy=1, don=0, out=new inp.
//    - No IDLE cycle is inserted.
//  6 Zeroize:
//    - With SREG_ZEROIZE_EN, the cycle after don shows out=0, rnd=0.
//    - Without it, the cycle after don still shows the final out and rnd=31.

Source files
------------

// File: rtl/sreg_rnd_if.sv
// sreg_rnd_if -- bus between the cipher top / round function (master) and the
// sreg_rnd state register (slave).
//
// Parameters:
//   W   state width in bits (bit 0 = MSB, state buses declared [0:W-1])
//   RW  round counter width
//
// Signals (direction seen from the slave):
//   sta  in   start: load inp and begin an operation
//   stl  in   stall: freeze state and round counter while running
//   inp  in   initial state data
//   nxt  in   next state from the round function (combinational from out, rnd)
//   out  out  registered state
//   rnd  out  registered round index of the state currently on out
//   bsy  out  high while an operation is running
//   don  out  one-cycle completion pulse; out holds the final state
//   st   out  current sequencer state (debug: 0 idle, 1 run, 2 done)
//
// Handshake: there is no ready/valid pair. sta and stl are levels sampled on
// every rising clock edge (sta has priority over stl). Completion is signalled
// by a single-cycle don pulse; out and rnd are valid in that cycle and the
// consumer must capture them then, since no back-pressure exists.
interface sreg_rnd_if #(
  parameter int W  = 64,
  parameter int RW = 5
);
  logic          sta;
  logic          stl;
  logic [0:W-1]  inp;
  logic [0:W-1]  nxt;
  logic [0:W-1]  out;
  logic [RW-1:0] rnd;
  logic          bsy;
  logic          don;
  logic [1:0]    st;

  modport master (
    output sta, stl, inp, nxt,
    input  out, rnd, bsy, don, st
  );

  modport slave (
    input  sta, stl, inp, nxt,
    output out, rnd, bsy, don, st
  );
endinterface

// File: rtl/sreg_rnd.sv
// sreg_rnd -- cipher state register with an integrated round sequencer.
//
// Loads an initial state on sta, applies ROUNDS updates taken from the round
// function (bus.nxt), then pulses don for one cycle with the final state on
// bus.out. sta restarts at any time; stl freezes state and counter while
// running. All outputs are registered.
//
// Parameters:
//   W       state width in bits
//   ROUNDS  number of nxt updates per operation (>= 1)
//   RW      round counter width, 2**RW must exceed ROUNDS
//
// Ports:
//   ck   rising-edge clock
//   rn   asynchronous active-low reset
//   bus  sreg_rnd_if slave modport (sta, stl, inp, nxt in; out, rnd, bsy,
//        don, st out)
//
// Build option: define SREG_ZEROIZE_EN to clear out and rnd on the
// DONE -> IDLE transition, so the final state is visible only while don is
// high. Without it, out and rnd hold their final values until the next start
// or reset.
module sreg_rnd #(
  parameter int W      = 64,
  parameter int ROUNDS = 31,
  parameter int RW     = 5
) (
  input  logic     ck,
  input  logic     rn,
  sreg_rnd_if.slave bus
);

  if (ROUNDS < 1 || (2 ** RW) <= ROUNDS) begin : g_param_check
    $error("sreg_rnd: need ROUNDS >= 1 and 2**RW > ROUNDS");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Round index before the final update edge.
  localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

  state_t        state, state_d;
  logic [0:W-1]  out_q, out_d;
  logic [RW-1:0] rnd_q, rnd_d;

  // State register, also holding the registered datapath outputs.
  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      state <= IDLE;
      out_q <= '0;
      rnd_q <= '0;
    end else begin
      state <= state_d;
      out_q <= out_d;
      rnd_q <= rnd_d;
    end
  end

  // Next-state logic. Priority on every edge: sta, then stl, then update.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (bus.sta) state_d = RUN;
      RUN: begin
        if (bus.sta)             state_d = RUN;
        else if (bus.stl)        state_d = RUN;
        else if (rnd_q == LAST)  state_d = DONE;
      end
      DONE:    state_d = bus.sta ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values. nxt is consumed only on an unstalled RUN update,
  // so the counter stops at ROUNDS and never wraps.
  always_comb begin
    out_d = out_q;
    rnd_d = rnd_q;
    case (state)
      IDLE: begin
        if (bus.sta) begin
          out_d = bus.inp;
          rnd_d = '0;
        end
      end
      RUN: begin
        if (bus.sta) begin
          out_d = bus.inp;
          rnd_d = '0;
        end else if (!bus.stl) begin
          out_d = bus.nxt;
          rnd_d = rnd_q + RW'(1);
        end
      end
      DONE: begin
        // stl has no effect here: DONE always lasts exactly one cycle.
        if (bus.sta) begin
          out_d = bus.inp;
          rnd_d = '0;
        end else begin
`ifdef SREG_ZEROIZE_EN
          out_d = '0;
          rnd_d = '0;
`else
          out_d = out_q;
          rnd_d = rnd_q;
`endif
        end
      end
      default: begin
        out_d = '0;
        rnd_d = '0;
      end
    endcase
  end

  // bsy and don decode the state register directly, so they are registered.
  assign bus.out = out_q;
  assign bus.rnd = rnd_q;
  assign bus.bsy = (state == RUN);
  assign bus.don = (state == DONE);
  assign bus.st  = state;

endmodule

// File: tb/tb_sreg_rnd.sv
// tb_sreg_rnd -- self-checking bench for sreg_rnd (W=64, ROUNDS=31, RW=5).
// The round function is modelled as nxt = out + 1, so an operation started
// with inp finishes with out = inp + ROUNDS. Expected final states are pushed
// to exp_q when an operation is started and popped when don is seen.
module tb_sreg_rnd;
  localparam int W      = 64;
  localparam int ROUNDS = 31;
  localparam int RW     = 5;

  logic ck = 1'b0;
  logic rn = 1'b1;
  always #5 ck = ~ck;

  sreg_rnd_if #(.W(W), .RW(RW)) bus ();
  assign bus.nxt = bus.out + W'(1);

  sreg_rnd #(.W(W), .ROUNDS(ROUNDS), .RW(RW)) dut (
    .ck  (ck),
    .rn  (rn),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  // All driving and sampling happens on the falling edge.
  task automatic start_op(input logic [W-1:0] d);
    bus.inp = d;
    bus.sta = 1'b1;
    @(negedge ck);
    bus.sta = 1'b0;
  endtask

  task automatic wait_don(input int budget, output int cycles, output bit timeout,
                          output int bsy_n);
    cycles  = 0;
    bsy_n   = 0;
    timeout = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (bus.don) begin
        timeout = 1'b0;
        break;
      end
      if (bus.bsy) bsy_n++;
      @(negedge ck);
      cycles++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int c;
    rn = 1'b0;
    repeat (2) @(negedge ck);
    n_checks++;
    if ({bus.out, bus.rnd, bus.bsy, bus.don} !== {W'(0), RW'(0), 2'b00}) begin
      n_fail++;
      $display("FAIL reset_state: out=%h rnd=%0d bsy=%b don=%b, required all zero",
               bus.out, bus.rnd, bus.bsy, bus.don);
    end
    rn = 1'b1;
    repeat (3) @(negedge ck);
    n_checks++;
    if (bus.bsy !== 1'b0 || bus.out !== W'(0)) begin
      n_fail++;
      $display("FAIL idle_after_reset: bsy=%b out=%h, required 0 and 0", bus.bsy, bus.out);
    end
    start_op(64'hDEAD_BEEF_0000_1111);
    for (int i = 0; i < 10; i++) @(negedge ck);
    n_checks++;
    if (bus.rnd !== RW'(10) || bus.bsy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_rnd: rnd=%0d bsy=%b, required 10 and 1", bus.rnd, bus.bsy);
    end
    // Assert reset mid-cycle, away from any clock edge.
    #2 rn = 1'b0;
    #1;
    n_checks++;
    if ({bus.out, bus.rnd, bus.bsy, bus.don} !== {W'(0), RW'(0), 2'b00}) begin
      n_fail++;
      $display("FAIL async_reset: out=%h rnd=%0d bsy=%b don=%b, required all zero",
               bus.out, bus.rnd, bus.bsy, bus.don);
    end
    @(negedge ck);
    rn = 1'b1;
    c = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ck);
      if (bus.bsy !== 1'b0 || bus.don !== 1'b0 || bus.out !== W'(0)) c++;
    end
    n_checks++;
    if (c != 0) begin
      n_fail++;
      $display("FAIL idle_until_sta: %0d busy/non-zero cycles, required 0", c);
    end
  endtask

  task automatic test_basic();
    int cyc, bn;
    bit to;
    logic [W-1:0] fin, e;
    start_op(64'h0123456789ABCDEF);
    exp_q.push_back(64'h0123456789ABCDEF + W'(ROUNDS));
    n_checks++;
    if (bus.out !== 64'h0123456789ABCDEF || bus.rnd !== RW'(0) || bus.bsy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_load: out=%h rnd=%0d bsy=%b, required 0123456789abcdef 0 1",
               bus.out, bus.rnd, bus.bsy);
    end
    wait_don(200, cyc, to, bn);
    n_checks++;
    if (to || cyc != ROUNDS || bn != ROUNDS) begin
      n_fail++;
      $display("FAIL basic_latency: timeout=%b cycles=%0d bsy_cycles=%0d, required 0 31 31",
               to, cyc, bn);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (bus.out !== e || bus.out !== 64'h0123456789ABCE0E || bus.rnd !== RW'(ROUNDS)
        || bus.bsy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_final: out=%h rnd=%0d bsy=%b, required %h 31 0",
               bus.out, bus.rnd, bus.bsy, e);
    end
    fin = bus.out;
    @(negedge ck);
    n_checks++;
    if (bus.don !== 1'b0 || bus.bsy !== 1'b0) begin
      n_fail++;
      $display("FAIL don_one_cycle: don=%b bsy=%b, required 0 0", bus.don, bus.bsy);
    end
`ifdef SREG_ZEROIZE_EN
    n_checks++;
    if (bus.out !== W'(0) || bus.rnd !== RW'(0)) begin
      n_fail++;
      $display("FAIL zeroize: out=%h rnd=%0d, required 0 0", bus.out, bus.rnd);
    end
`else
    n_checks++;
    if (bus.out !== fin || bus.rnd !== RW'(ROUNDS)) begin
      n_fail++;
      $display("FAIL hold_final: out=%h rnd=%0d, required %h 31", bus.out, bus.rnd, fin);
    end
`endif
  endtask

  task automatic test_stall();
    int cyc, bn, bad;
    bit to;
    logic [W-1:0] e;
    start_op(64'h0123456789ABCDEF);
    exp_q.push_back(64'h0123456789ABCDEF + W'(ROUNDS));
    for (int i = 0; i < 7; i++) @(negedge ck);
    n_checks++;
    if (bus.rnd !== RW'(7) || bus.out !== 64'h0123456789ABCDEF + 64'd7) begin
      n_fail++;
      $display("FAIL stall_pre: rnd=%0d out=%h, required 7 0123456789abcdf6", bus.rnd, bus.out);
    end
    bad = 0;
    bus.stl = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ck);
      if (bus.rnd !== RW'(7) || bus.out !== 64'h0123456789ABCDEF + 64'd7 || bus.bsy !== 1'b1)
        bad++;
    end
    bus.stl = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_freeze: %0d stalled cycles moved, required 0", bad);
    end
    wait_don(200, cyc, to, bn);
    n_checks++;
    if (to || 7 + 5 + cyc != ROUNDS + 5) begin
      n_fail++;
      $display("FAIL stall_latency: timeout=%b total=%0d, required 0 36", to, 12 + cyc);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (bus.out !== e || bus.rnd !== RW'(ROUNDS)) begin
      n_fail++;
      $display("FAIL stall_final: out=%h rnd=%0d, required %h 31", bus.out, bus.rnd, e);
    end
    @(negedge ck);
  endtask

  task automatic test_restart();
    int cyc, bn;
    bit to;
    logic [W-1:0] e;
    start_op({$urandom(), $urandom()});
    for (int i = 0; i < 20; i++) @(negedge ck);
    n_checks++;
    if (bus.rnd !== RW'(20)) begin
      n_fail++;
      $display("FAIL restart_pre: rnd=%0d, required 20", bus.rnd);
    end
    bus.inp = '0;
    bus.sta = 1'b1;
    bus.stl = 1'b1;
    @(negedge ck);
    bus.sta = 1'b0;
    bus.stl = 1'b0;
    exp_q.push_back(W'(0) + W'(ROUNDS));
    n_checks++;
    if (bus.out !== W'(0) || bus.rnd !== RW'(0) || bus.bsy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_priority: out=%h rnd=%0d bsy=%b, required 0 0 1",
               bus.out, bus.rnd, bus.bsy);
    end
    wait_don(200, cyc, to, bn);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (to || cyc != ROUNDS || bus.out !== e || bus.out !== 64'h1F) begin
      n_fail++;
      $display("FAIL restart_final: timeout=%b cycles=%0d out=%h, required 0 31 %h",
               to, cyc, bus.out, e);
    end
    @(negedge ck);
  endtask

  task automatic test_back_to_back();
    int cyc, bn;
    bit to;
    logic [W-1:0] d1, d2, e;
    d1 = {$urandom(), $urandom()};
    d2 = {$urandom(), $urandom()};
    start_op(d1);
    exp_q.push_back(d1 + W'(ROUNDS));
    wait_don(200, cyc, to, bn);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (to || bus.out !== e) begin
      n_fail++;
      $display("FAIL b2b_first: timeout=%b out=%h, required 0 %h", to, bus.out, e);
    end
    // Start again in the don cycle: no idle cycle must be inserted.
    start_op(d2);
    exp_q.push_back(d2 + W'(ROUNDS));
    n_checks++;
    if (bus.bsy !== 1'b1 || bus.don !== 1'b0 || bus.out !== d2 || bus.rnd !== RW'(0)) begin
      n_fail++;
      $display("FAIL b2b_restart: bsy=%b don=%b out=%h rnd=%0d, required 1 0 %h 0",
               bus.bsy, bus.don, bus.out, bus.rnd, d2);
    end
    wait_don(200, cyc, to, bn);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (to || cyc != ROUNDS || bus.out !== e || bus.rnd !== RW'(ROUNDS)) begin
      n_fail++;
      $display("FAIL b2b_second: timeout=%b cycles=%0d out=%h rnd=%0d, required 0 31 %h 31",
               to, cyc, bus.out, bus.rnd, e);
    end
    @(negedge ck);
  endtask

  task automatic test_sta_held();
    int bad, cyc, bn;
    bit to;
    logic [W-1:0] d;
    bad = 0;
    bus.sta = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d = {$urandom(), $urandom()};
      bus.inp = d;
      @(negedge ck);
      if (bus.rnd !== RW'(0) || bus.don !== 1'b0 || bus.out !== d) bad++;
    end
    bus.sta = 1'b0;
    exp_q.push_back(d + W'(ROUNDS));
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL sta_held: %0d cycles with rnd!=0, don or stale out, required 0", bad);
    end
    wait_don(200, cyc, to, bn);
    d = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (to || cyc != ROUNDS || bus.out !== d) begin
      n_fail++;
      $display("FAIL sta_held_release: timeout=%b cycles=%0d out=%h, required 0 31 %h",
               to, cyc, bus.out, d);
    end
    @(negedge ck);
  endtask

  task automatic test_random_stall();
    int cyc, stalls;
    logic [W-1:0] d, e;
    for (int n = 0; n < 4; n++) begin
      d = {$urandom(), $urandom()};
      start_op(d);
      exp_q.push_back(d + W'(ROUNDS));
      cyc = 0;
      stalls = 0;
      while (!bus.don && cyc < 300) begin
        bus.stl = ($urandom_range(0, 3) == 0);
        if (bus.stl) stalls++;
        @(negedge ck);
        cyc++;
      end
      bus.stl = 1'b0;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (bus.don !== 1'b1 || cyc != ROUNDS + stalls || bus.out !== e
          || bus.rnd !== RW'(ROUNDS)) begin
        n_fail++;
        $display("FAIL rand_stall_%0d: don=%b cycles=%0d out=%h rnd=%0d, required 1 %0d %h 31",
                 n, bus.don, cyc, bus.out, bus.rnd, ROUNDS + stalls, e);
      end
      @(negedge ck);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.sta = 1'b0;
    bus.stl = 1'b0;
    bus.inp = '0;
    #2;
    test_reset();
    test_basic();
    test_stall();
    test_restart();
    test_back_to_back();
    test_sta_held();
    test_random_stall();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
